// File: rtl/sdram_read_responder_pkg.sv
// sdram_read_responder_pkg: shared types and constants for the ROM read path on the SDRAM side.
package sdram_read_responder_pkg;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LO, WAIT_HI, DONE} state_t;
   localparam int SDRAM_BURST_WORDS = 2;
   localparam int BEAT_W = 16;
   localparam int DEFAULT_TIMEOUT = 64;
   localparam logic [24:0] TILE_ROM_BASE = 25'h000_0000;
   localparam logic [24:0] SPRITE_ROM_BASE = 25'h080_0000;
endpackage

// File: rtl/sdram_read_responder_if.sv
// sdram_read_responder_if: request/response bus plus SDRAM-core command bus of the read responder.
interface sdram_read_responder_if #(parameter int ADDR_W = 25);
   import sdram_read_responder_pkg::*;
   logic req;
   logic [ADDR_W-1:0] addr;
   logic [SDRAM_BURST_WORDS*BEAT_W-1:0] data;
   logic rdy;
   logic busy;
   logic overrun;
   logic timeout_err;
   logic core_req;
   logic [ADDR_W-2:0] core_addr;
   logic core_ack;
   logic [BEAT_W-1:0] core_data;
   logic core_valid;
   modport master (
      output req, addr, core_ack, core_data, core_valid,
      input data, rdy, busy, overrun, timeout_err, core_req, core_addr
   );
   modport slave (
      input req, addr, core_ack, core_data, core_valid,
      output data, rdy, busy, overrun, timeout_err, core_req, core_addr
   );
endinterface

// File: rtl/sdram_read_responder_req_slot.sv
// sdram_req_slot: one-entry holder for a request that arrives while the responder is busy.
module sdram_req_slot #(parameter int ADDR_W = 25) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic              i_idle,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              o_valid,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_overrun
);
   logic r_valid, r_overrun;
   logic [ADDR_W-1:0] r_addr;
   logic w_pop, w_store;
   // An idle FSM always consumes a held entry, which frees the slot for a same-cycle req.
   assign w_pop = i_idle && r_valid;
   assign w_store = i_req && (w_pop || (!r_valid && !i_idle));
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_addr <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_store) r_addr <= i_addr;
         r_valid <= w_store || (r_valid && !w_pop);
         r_overrun <= r_overrun || (i_req && r_valid && !w_pop);
      end
   end
   assign o_valid = r_valid;
   assign o_addr = r_addr;
   assign o_overrun = r_overrun;
endmodule

// File: rtl/sdram_read_responder.sv
// sdram_read_responder: turns a read pulse into a 2-beat SDRAM read and returns the 32-bit result.
module sdram_read_responder
   import sdram_read_responder_pkg::*;
#(
   parameter int ADDR_W = 25,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input logic clk,
   input logic reset,
   sdram_read_responder_if.slave bus
);
   localparam int CW = $clog2(TIMEOUT);
   localparam int WA_W = ADDR_W - 1;
   state_t r_state;
   logic [CW-1:0] r_cnt;
   logic [BEAT_W-1:0] r_lo;
   logic [SDRAM_BURST_WORDS*BEAT_W-1:0] r_data;
   logic r_rdy, r_terr, r_busy, r_creq;
   logic [WA_W-1:0] r_caddr;
   logic w_pv;
   logic [ADDR_W-1:0] w_pa, w_sel;
   sdram_req_slot #(.ADDR_W(ADDR_W)) u_slot (
      .clk(clk),
      .reset(reset),
      .i_req(bus.req),
      .i_idle(r_state == IDLE),
      .i_addr(bus.addr),
      .o_valid(w_pv),
      .o_addr(w_pa),
      .o_overrun(bus.overrun)
   );
   assign w_sel = w_pv ? w_pa : bus.addr;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt <= '0;
         r_lo <= '0;
         r_data <= '0;
         r_rdy <= 1'b0;
         r_terr <= 1'b0;
         r_busy <= 1'b0;
         r_creq <= 1'b0;
         r_caddr <= '0;
      end else begin
         r_rdy <= 1'b0;
         r_terr <= 1'b0;
         r_busy <= (r_state != IDLE) || w_pv;
         case (r_state)
            IDLE: if (w_pv || bus.req) begin
               r_caddr <= WA_W'((w_sel >> 2) << 1);
               r_creq <= 1'b1;
               r_cnt <= '0;
               r_state <= ISSUE;
            end
            DONE: begin
               r_rdy <= 1'b1;
               r_state <= IDLE;
            end
            default: if (r_cnt == CW'(TIMEOUT - 1)) begin
               r_creq <= 1'b0;
               r_data <= '0;
               r_rdy <= 1'b1;
               r_terr <= 1'b1;
               r_state <= IDLE;
            end else begin
               r_cnt <= r_cnt + CW'(1);
               // A beat arriving with the ack is the low half, so WAIT_LO is skipped.
               if (r_state == ISSUE && bus.core_ack) begin
                  r_creq <= 1'b0;
                  r_lo <= bus.core_data;
                  r_state <= bus.core_valid ? WAIT_HI : WAIT_LO;
               end
               if (r_state == WAIT_LO && bus.core_valid) begin
                  r_lo <= bus.core_data;
                  r_state <= WAIT_HI;
               end
               if (r_state == WAIT_HI && bus.core_valid) begin
                  r_data <= {bus.core_data, r_lo};
                  r_state <= DONE;
               end
            end
         endcase
      end
   end
   assign bus.data = r_data;
   assign bus.rdy = r_rdy;
   assign bus.timeout_err = r_terr;
   assign bus.busy = r_busy;
   assign bus.core_req = r_creq;
   assign bus.core_addr = r_caddr;
endmodule
